uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and launch sequencer that shares one UART transmitter between NUM_REQ independent requesters. It sits directly in front of the UART TX top level. It selects a requester, latches that requester's byte and parity configuration, and issues a single-cycle Data_valid. It holds the latched P_data/Par_en/Par_type stable for the whole frame, then releases the link when Busy falls.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- width, 8: data word width; must match the transmitter's width.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester request; bit i belongs to requester i.
- req_data  in  NUM_REQ*width  requester i's data in bits [i*width +: width].
- req_par_en  in  NUM_REQ  per-requester parity enable.
- req_par_type  in  NUM_REQ  per-requester parity type (0 even, 1 odd).
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse to the granted requester.
- Data_valid  out  1  launch pulse to the transmitter.
- P_data  out  width  latched word to the transmitter.
- Par_en  out  1  latched parity enable.
- Par_type  out  1  latched parity type.
- Busy  in  1  transmitter busy.
- grant_id  out  $clog2(NUM_REQ)  index of the last granted requester.
- arb_active  out  1  high from launch until the frame completes.
- launch_err  out  1  1-cycle pulse when the transmitter fails to acknowledge a launch.

## Operation
- Registered FSM with states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
- IDLE, transition condition: when any req_valid is 1 and Busy is 0, pick the winner and capture its data, par_en and par_type into the P_data/Par_en/Par_type registers.
- IDLE, actions on that transition: set grant_id, advance the round-robin pointer to winner+1 mod NUM_REQ, and go to LAUNCH.
- IDLE, otherwise: stay.
- LAUNCH lasts exactly one cycle:
  - Data_valid is 1 and req_ready[grant_id] is 1.
  - Clear the timeout counter, then go to WAIT_BUSY.
- WAIT_BUSY:
  - Busy=1 → WAIT_DONE.
  - Otherwise increment the 2-bit timeout counter. When it reaches 3, pulse launch_err for one cycle and go to IDLE.
- WAIT_DONE: Busy=0 → IDLE; otherwise stay.
- Round-robin search starts at the pointer and wraps at NUM_REQ-1 → 0. The pointer's reset value is 0.
- P_data, Par_en and Par_type change only on the IDLE→LAUNCH capture. They are held through WAIT_DONE and after it.
- arb_active is 1 in LAUNCH, WAIT_BUSY and WAIT_DONE.
- Requester contract:
  - Hold req_valid and the payload stable until req_ready is seen.
  - Drop or replace them by the cycle after req_ready.
  - A req_valid withdrawn while in IDLE before capture is simply not granted.
- Reset values: all outputs are 0, state is IDLE, the pointer is 0 and the timeout counter is 0.

## Timing
- Grant latency: req_valid=1 sampled in IDLE at edge t gives Data_valid and req_ready high for the cycle after edge t+1.
- The transmitter raises Busy 1 cycle after Data_valid. WAIT_BUSY normally lasts 1 cycle.
- Back-to-back requests:
  - Busy falling is sampled in WAIT_DONE at edge t, so IDLE is entered at t+1.
  - The next Data_valid comes at t+2, which gives a minimum 2-cycle gap from Busy low to the next launch.
- If Busy is already 1 while in IDLE (for example, another master), no grant is made.
- If rst=0 is sampled mid-frame, the block returns to IDLE on the next edge and Data_valid is forced to 0. Requesters must re-request.
- Simultaneous requests are resolved in the same cycle by the pointer order. No requester waits more than NUM_REQ grants.

## Configuration
- UART_TX_ARB_FIXED_PRI_EN:
  - Defined: fixed priority, lowest index wins, and the pointer is unused (held at 0).
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single request: req_valid=4'b0010, req_data[15:8]=8'hA5, par_en=1, par_type=1.
  - Expect exactly one Data_valid with P_data=8'hA5, Par_en=1, Par_type=1.
  - Expect req_ready=4'b0010 and grant_id=1.
  - P_data must be stable until Busy falls.
- Contention, round-robin: all four requesters held valid continuously for 8 frames.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Each gap from Busy low to the next Data_valid is 2 cycles.
- Fixed priority (macro defined): the same stimulus as the contention test.
  - Expect every grant to go to requester 0 while it stays valid.
  - Expect requester 1 to win once requester 0 drops.
- Missing acknowledge: force Busy=0 permanently and issue one request.
  - Expect launch_err pulsed 4 cycles after Data_valid and a return to IDLE.
  - A still-valid requester is re-granted.
- Reset mid-frame: assert rst=0 for 1 cycle while in WAIT_DONE with Busy=1.
  - All outputs are 0 on the next cycle and the state is IDLE.
  - No grant is made until Busy=0.
- Withdrawn request: pulse req_valid[2] for 1 cycle while Busy=1.
  - Expect no grant and no Data_valid after Busy falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and launch sequencer sharing one UART transmitter among NUM_REQ requesters.
// Define UART_TX_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int width   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*width-1:0]   req_data,
   input  logic [NUM_REQ-1:0]         req_par_en,
   input  logic [NUM_REQ-1:0]         req_par_type,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       Data_valid,
   output logic [width-1:0]           P_data,
   output logic                       Par_en,
   output logic                       Par_type,
   input  logic                       Busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       arb_active,
   output logic                       launch_err
);

   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   winner;
   logic [IDW-1:0]   idx;
   logic             found;
   logic [1:0]       to_cnt;
   logic             capture;
   logic             set_err;
   logic [width-1:0] sel_data;

   // Search starts at the pointer and wraps, so the first valid requester after the last winner wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
         idx = (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

   assign sel_data = req_data[int'(winner)*width +: width];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      set_err    = 1'b0;
      Data_valid = 1'b0;
      req_ready  = '0;
      arb_active = (state != IDLE);
      case (state)
         IDLE: begin
            if (found && !Busy) begin
               capture    = 1'b1;
               next_state = LAUNCH;
            end
         end
         LAUNCH: begin
            Data_valid          = 1'b1;
            req_ready[grant_id] = 1'b1;
            next_state          = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (Busy) begin
               next_state = WAIT_DONE;
            end else if (to_cnt == 2'd2) begin
               set_err    = 1'b1;
               next_state = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!Busy) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // The launched payload is frozen at capture so the transmitter sees it stable for the whole frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr     <= '0;
         to_cnt     <= 2'd0;
         P_data     <= '0;
         Par_en     <= 1'b0;
         Par_type   <= 1'b0;
         grant_id   <= '0;
         launch_err <= 1'b0;
      end else begin
         launch_err <= set_err;
         if (capture) begin
            P_data   <= sel_data;
            Par_en   <= req_par_en[winner];
            Par_type <= req_par_type[winner];
            grant_id <= winner;
`ifdef UART_TX_ARB_FIXED_PRI_EN
            rr_ptr   <= '0;
`else
            rr_ptr   <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`endif
         end
         if (state == LAUNCH) begin
            to_cnt <= 2'd0;
         end else if (state == WAIT_BUSY && !Busy) begin
            to_cnt <= to_cnt + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model driving Busy.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_par_en;
   logic [NUM_REQ-1:0]       req_par_type;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     Data_valid;
   logic [WIDTH-1:0]         P_data;
   logic                     Par_en;
   logic                     Par_type;
   logic                     Busy;
   logic [1:0]               grant_id;
   logic                     arb_active;
   logic                     launch_err;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   frame_len = 6;
   bit   tx_en = 1'b0;

   logic [7:0] data_tbl [4] = '{8'h0F, 8'hA5, 8'h5A, 8'h3C};
   logic [3:0] pen_tbl  = 4'b0110;
   logic [3:0] ptyp_tbl = 4'b1010;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .width(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_par_en   (req_par_en),
      .req_par_type (req_par_type),
      .req_ready    (req_ready),
      .Data_valid   (Data_valid),
      .P_data       (P_data),
      .Par_en       (Par_en),
      .Par_type     (Par_type),
      .Busy         (Busy),
      .grant_id     (grant_id),
      .arb_active   (arb_active),
      .launch_err   (launch_err)
   );

   always #5 clk = ~clk;

   // Transmitter model: raises Busy one cycle after a launch and holds it for frame_len cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_en && Data_valid) begin
            @(posedge clk);
            #1 Busy = 1'b1;
            repeat (frame_len) @(posedge clk);
            #1 Busy = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] valid);
      req_valid = valid;
   endtask

   task automatic waitDataValid(input string tag);
      int n;
      n = 0;
      while (Data_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_launch_seen"}, 32'(Data_valid), 32'd1);
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while ((arb_active || Busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_idle"}, 32'(arb_active | Busy), 32'd0);
   endtask

   initial begin
      int  n;
      int  gap;
      int  extra;
      int  exp_id;
      bit  stable;
      bit  launched;

      rst          = 1'b0;
      Busy         = 1'b0;
      req_valid    = '0;
      req_data     = {data_tbl[3], data_tbl[2], data_tbl[1], data_tbl[0]};
      req_par_en   = pen_tbl;
      req_par_type = ptyp_tbl;

      repeat (2) @(negedge clk);
      checkOutput("rst_data_valid", 32'(Data_valid), 32'd0);
      checkOutput("rst_req_ready",  32'(req_ready),  32'd0);
      checkOutput("rst_p_data",     32'(P_data),     32'd0);
      checkOutput("rst_par_en",     32'(Par_en),     32'd0);
      checkOutput("rst_par_type",   32'(Par_type),   32'd0);
      checkOutput("rst_grant_id",   32'(grant_id),   32'd0);
      checkOutput("rst_arb_active", 32'(arb_active), 32'd0);
      checkOutput("rst_launch_err", 32'(launch_err), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single request from requester 1
      tx_en     = 1'b1;
      frame_len = 10;
      applyStimulus(4'b0010);
      waitDataValid("single");
      checkOutput("single_req_ready",  32'(req_ready),  32'h2);
      checkOutput("single_grant_id",   32'(grant_id),   32'd1);
      checkOutput("single_p_data",     32'(P_data),     32'hA5);
      checkOutput("single_par_en",     32'(Par_en),     32'd1);
      checkOutput("single_par_type",   32'(Par_type),   32'd1);
      checkOutput("single_arb_active", 32'(arb_active), 32'd1);
      applyStimulus(4'b0000);
      @(negedge clk);
      checkOutput("single_dv_one_cycle", 32'(Data_valid), 32'd0);
      stable = 1'b1;
      extra  = 0;
      n      = 0;
      while ((Busy || arb_active) && n < 100) begin
         if (P_data !== 8'hA5) stable = 1'b0;
         if (Data_valid) extra++;
         @(negedge clk);
         n++;
      end
      checkOutput("single_frame_done",  32'(n < 100),  32'd1);
      checkOutput("single_pdata_held",  32'(stable),   32'd1);
      checkOutput("single_extra_launch", 32'(extra),   32'd0);
      checkOutput("single_pdata_after", 32'(P_data),   32'hA5);

      // Contention: all requesters valid for 8 frames, then requester 0 drops
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      frame_len = 6;
      applyStimulus(4'b1111);
      for (int k = 0; k < 9; k++) begin
         gap = 0;
         n   = 0;
         @(negedge clk);
         while (!Data_valid && n < 100) begin
            if (Busy) gap = 0;
            else gap++;
            @(negedge clk);
            n++;
         end
         checkOutput($sformatf("rr%0d_launch_seen", k), 32'(Data_valid), 32'd1);
`ifdef UART_TX_ARB_FIXED_PRI_EN
         exp_id = (k < 8) ? 0 : 1;
`else
         exp_id = (k < 8) ? (k % 4) : 1;
`endif
         checkOutput($sformatf("rr%0d_grant_id", k),  32'(grant_id),  32'(exp_id));
         checkOutput($sformatf("rr%0d_req_ready", k), 32'(req_ready), 32'(4'b0001 << exp_id));
         checkOutput($sformatf("rr%0d_p_data", k),    32'(P_data),    32'(data_tbl[exp_id]));
         checkOutput($sformatf("rr%0d_par_type", k),  32'(Par_type),  32'(ptyp_tbl[exp_id]));
         if (k > 0) checkOutput($sformatf("rr%0d_gap", k), 32'(gap), 32'd2);
         if (k == 7) applyStimulus(4'b1110);
         if (k == 8) applyStimulus(4'b0000);
      end
      waitIdle("rr");

      // Missing acknowledge: transmitter never raises Busy
      tx_en = 1'b0;
      applyStimulus(4'b1000);
      waitDataValid("noack");
      checkOutput("noack_grant_id", 32'(grant_id), 32'd3);
      n = 0;
      while (!launch_err && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("noack_err_delay",  32'(n),          32'd4);
      checkOutput("noack_err_idle",   32'(arb_active), 32'd0);
      @(negedge clk);
      checkOutput("noack_err_pulse",  32'(launch_err), 32'd0);
      checkOutput("noack_regrant_dv", 32'(Data_valid), 32'd1);
      checkOutput("noack_regrant_id", 32'(grant_id),   32'd3);
      applyStimulus(4'b0000);
      n = 0;
      while (!launch_err && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("noack_second_err", 32'(launch_err), 32'd1);
      waitIdle("noack");

      // Reset during WAIT_DONE while the transmitter is still busy
      tx_en     = 1'b1;
      frame_len = 20;
      applyStimulus(4'b0100);
      waitDataValid("rstmid");
      checkOutput("rstmid_p_data", 32'(P_data), 32'h5A);
      applyStimulus(4'b0000);
      repeat (4) @(negedge clk);
      checkOutput("rstmid_busy",   32'(Busy),       32'd1);
      checkOutput("rstmid_active", 32'(arb_active), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checkOutput("rstmid_data_valid", 32'(Data_valid), 32'd0);
      checkOutput("rstmid_req_ready",  32'(req_ready),  32'd0);
      checkOutput("rstmid_p_data_clr", 32'(P_data),     32'd0);
      checkOutput("rstmid_par_en",     32'(Par_en),     32'd0);
      checkOutput("rstmid_grant_id",   32'(grant_id),   32'd0);
      checkOutput("rstmid_arb_active", 32'(arb_active), 32'd0);
      checkOutput("rstmid_launch_err", 32'(launch_err), 32'd0);
      applyStimulus(4'b0100);
      launched = 1'b0;
      n = 0;
      while (Busy && n < 100) begin
         if (Data_valid) launched = 1'b1;
         @(negedge clk);
         n++;
      end
      checkOutput("rstmid_no_grant_busy", 32'(launched), 32'd0);
      waitDataValid("rstmid_regrant");
      checkOutput("rstmid_regrant_id", 32'(grant_id), 32'd2);
      applyStimulus(4'b0000);
      waitIdle("rstmid");

      // Withdrawn request while Busy is held by another master
      tx_en = 1'b0;
      Busy  = 1'b1;
      @(negedge clk);
      applyStimulus(4'b0100);
      @(negedge clk);
      applyStimulus(4'b0000);
      @(negedge clk);
      Busy = 1'b0;
      launched = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (Data_valid) launched = 1'b1;
      end
      checkOutput("withdrawn_no_launch", 32'(launched),   32'd0);
      checkOutput("withdrawn_idle",      32'(arb_active), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
